sha256_axi_lite_slave: RTL

//  AXI4-Lite responder at the S00_AXI port of the sha256 IP; the far end of the master BFM transactions.

---
 rtl/sha256_axi_lite_slave.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sha256_axi_lite_slave.sv
// AXI4-Lite register slave for the sha256 core: four RW control/message
// registers, RO digest and status words, and a one-cycle start pulse.
module sha256_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [127:0]                      reg_o,
    output logic                              start_o,
    input  logic [255:0]                      digest_i,
    input  logic                              done_i,
    input  logic                              busy_i
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t          r_wstate, w_wnext;
    rstate_t          r_rstate, w_rnext;
    logic [3:0][31:0] r_regs;
    logic [31:0]      r_rdata;
    logic             r_start;
    logic             w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic             w_wr_en, w_rd_en;
    logic [3:0]       w_widx, w_ridx;
    logic [2:0]       w_didx;
    logic [31:0]      w_rmux;
    logic             w_unused;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_widx = S_AXI_AWADDR[5:2];
    assign w_ridx = S_AXI_ARADDR[5:2];
    assign w_didx = 3'(w_ridx - 4'd4);

    // Write state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_wstate <= W_IDLE;
        else              r_wstate <= w_wnext;
    end

    // Write next-state and handshake outputs; AW and W are only taken together
    always_comb begin
        w_wnext   = r_wstate;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_wnext = W_ACK;
            W_ACK: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                w_wnext   = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (S_AXI_BREADY) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    assign w_wr_en = (r_wstate == W_ACK);

    // Register file update per byte strobe, plus start pulse on a go-bit write to reg0
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_regs  <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_wr_en && (w_widx == 4'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
            if (w_wr_en && (w_widx[3:2] == 2'b00)) begin
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b]) r_regs[w_widx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Read state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_rstate <= R_IDLE;
        else              r_rstate <= w_rnext;
    end

    // Read next-state and handshake outputs
    always_comb begin
        w_rnext   = r_rstate;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: if (S_AXI_ARVALID) w_rnext = R_ACK;
            R_ACK: begin
                w_arready = 1'b1;
                w_rnext   = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    assign w_rd_en = (r_rstate == R_ACK);

    // Read address decode: RW regs, digest words, status, then zeros
    always_comb begin
        w_rmux = 32'h0;
        if (w_ridx < 4'd4)       w_rmux = r_regs[w_ridx[1:0]];
        else if (w_ridx < 4'd12) w_rmux = digest_i[32*w_didx +: 32];
        else if (w_ridx == 4'd12) w_rmux = {30'b0, busy_i, done_i};
    end

    // Capture read data on the ARREADY edge and hold it until RREADY
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_rdata <= '0;
        else if (w_rd_en) r_rdata <= w_rmux;
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign reg_o         = r_regs;
    assign start_o       = r_start;

endmodule
